// File: rtl/spi_valrdy_responder.sv
// SPI mode-0 minion responder with val/rdy streams.
//
// Receives fixed-length, MSB-first frames on mosi and pushes each complete
// word into a small FIFO that drains over the send stream. During the same
// frame it shifts out on miso a word previously accepted on the recv stream,
// or zeros if none was waiting.
//
// Ports:
//   clk, reset        system clock, async active-low reset
//   cs, sclk, mosi    SPI inputs (asynchronous, synchronized internally)
//   miso              SPI output
//   recv_val/rdy/msg  transmit word stream (into the 1-entry tx buffer)
//   send_val/rdy/msg  received word stream (out of the FIFO)
//   parity            XOR of the last word pushed into the FIFO
//   overflow          sticky: complete frame dropped, FIFO full
//   frame_err         sticky: frame ended with the wrong bit count
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | cs high (or not yet armed); miso driven low
// SHIFT | frame in progress; sample mosi on sclk rise, shift on fall

module spi_valrdy_responder #(
  parameter int BIT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs,
  input  logic                 sclk,
  input  logic                 mosi,
  output logic                 miso,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  input  logic [BIT_WIDTH-1:0] recv_msg,
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [BIT_WIDTH-1:0] send_msg,
  output logic                 parity,
  output logic                 overflow,
  output logic                 frame_err
);

  localparam int CNT_W = $clog2(BIT_WIDTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BIT_WIDTH);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state, state_nxt;

  logic cs_s1, cs_s2, cs_prev;
  logic sclk_s1, sclk_s2, sclk_s3;
  logic mosi_s1, mosi_s2;
  logic [1:0] warm;
  logic armed;

  logic [CNT_W-1:0]     bit_cnt;
  logic [BIT_WIDTH-1:0] tx_shift, rx_shift, tx_buf;
  logic                 tx_val;

  logic [BIT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [OCC_W-1:0]     occ;

  logic cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic frame_full, fifo_full, push, pop, drop;

  // warm is a two-stage "out of reset" pipe: warm[0] enables recv_rdy from
  // the first edge, warm[1] marks cs_s2 as holding a real sample. armed
  // requires cs to be seen high after reset, so a frame already in progress
  // at release is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_prev <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      warm    <= 2'b00;
      armed   <= 1'b0;
    end else begin
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
      cs_prev <= cs_s2;
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      warm    <= {warm[0], 1'b1};
      armed   <= armed | (warm[1] & cs_s2);
    end
  end

  assign cs_fall   = armed & cs_prev & ~cs_s2;
  assign cs_rise   = ~cs_prev & cs_s2;
  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;

  assign recv_rdy = warm[0] & ~tx_val;

  assign pop        = send_val & send_rdy;
  assign fifo_full  = (occ == OCC_FULL);
  assign frame_full = (state == SHIFT) && cs_rise && (bit_cnt == CNT_FULL);
  assign push       = frame_full & (~fifo_full | pop);
  assign drop       = frame_full & fifo_full & ~pop;

  always_comb begin
    state_nxt = state;
    miso      = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) state_nxt = SHIFT;
      end
      SHIFT: begin
        miso = tx_shift[BIT_WIDTH-1];
        if (cs_rise) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      tx_buf    <= '0;
      tx_val    <= 1'b0;
      parity    <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_nxt;

      // Load and consume never coincide: recv_rdy is low whenever tx_val is set.
      if (recv_val && recv_rdy) begin
        tx_buf <= recv_msg;
        tx_val <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            if (tx_val) begin
              tx_shift <= tx_buf;
              tx_val   <= 1'b0;
            end else begin
              tx_shift <= '0;
            end
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            if (bit_cnt != CNT_FULL) frame_err <= 1'b1;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[BIT_WIDTH-2:0], mosi_s2};
            if (bit_cnt != CNT_FULL) bit_cnt <= bit_cnt + 1'b1;
          end else if (sclk_fall && bit_cnt != '0) begin
            tx_shift <= {tx_shift[BIT_WIDTH-2:0], 1'b0};
          end
        end
        default: ;
      endcase

      if (push) parity <= ^rx_shift;
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rx_shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign send_val = (occ != '0);
  assign send_msg = mem[rd_ptr];

endmodule

// File: doc/spi_valrdy_responder.md
Name: spi_valrdy_responder

Overview:
- SPI minion-side responder. It is the far end of a link driven by the interconnect's SPI master, and is used on test chips and as the loopback target in interconnect benches.
- Captures full-duplex, fixed-length, MSB-first SPI mode-0 frames on mosi.
- Delivers each received word on a val/rdy send stream.
- Shifts a word taken from a val/rdy recv stream out on miso during the same frame.

Parameters:
- BIT_WIDTH, 32, SPI frame length and stream message width in bits.
- FIFO_DEPTH, 2, entries in the received-word FIFO; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock; all logic is in this domain.
- reset  input  1  asynchronous, active-low reset.
- cs  input  1  SPI chip select, active-low, asynchronous to clk.
- sclk  input  1  SPI clock, asynchronous to clk.
- mosi  input  1  SPI data from the master.
- miso  output  1  SPI data to the master.
- recv_val  input  1  word to transmit is valid.
- recv_rdy  output  1  transmit buffer can accept a word.
- recv_msg  input  BIT_WIDTH  word to transmit on the next frame.
- send_val  output  1  received word available.
- send_rdy  input  1  downstream accepts the word.
- send_msg  output  BIT_WIDTH  oldest received word.
- parity  output  1  XOR-reduction of the last word pushed into the FIFO.
- overflow  output  1  sticky: a complete frame was dropped because the FIFO was full.
- frame_err  output  1  sticky: cs deasserted with bit count not equal to BIT_WIDTH.

Behaviour:
- Reset (reset=0, asynchronous) sets the following:
  - Synchronizers: cs=1, sclk=0, mosi=0.
  - State IDLE, bit_cnt=0, shift registers=0, tx buffer empty, FIFO empty.
  - Outputs: miso=0, recv_rdy=0 while reset is asserted and 1 from the first clk edge after release, send_val=0, send_msg=0, parity=0, overflow=0, frame_err=0.
- Synchronization: cs, sclk and mosi each pass through 2 flops; one further sclk flop gives rise/fall detection. SCLK high and low phases must each be at least 3 clk periods. cs falling must precede the first sclk rise by at least 3 clk periods.
- Transmit buffer:
  - 1 entry; recv_rdy = !tx_val. A handshake (recv_val && recv_rdy) loads tx_buf and sets tx_val.
  - At the start of a frame the buffer is consumed using its pre-edge state. A word handshaken in the same cycle as the cs-fall detection goes to the next frame.
- FSM IDLE:
  - miso=0.
  - On synced cs falling: if tx_val, tx_shift<=tx_buf and tx_val<=0; otherwise tx_shift<=0. Then bit_cnt<=0 and go to SHIFT.
- FSM SHIFT:
  - miso = tx_shift[BIT_WIDTH-1].
  - On sclk rise: rx_shift<={rx_shift[BIT_WIDTH-2:0], mosi_sync}; bit_cnt increments, saturating at BIT_WIDTH.
  - On sclk fall with bit_cnt>0: tx_shift<<=1, shifting in zeros. The first bit is presented before the first rise.
  - On synced cs rising, go to IDLE and:
    - bit_cnt==BIT_WIDTH and FIFO not full: push rx_shift and set parity<=^rx_shift.
    - bit_cnt==BIT_WIDTH and FIFO full with no pop in that cycle: drop the word and set overflow<=1.
    - bit_cnt!=BIT_WIDTH: discard the word and set frame_err<=1. The consumed tx word is lost.
- Received FIFO:
  - Standard circular buffer with wrap-around pointers and a count. send_val = count!=0; send_msg = head entry.
  - A push and a pop in the same cycle are both accepted, including when full; count is unchanged.
  - Push-to-send_val latency is 1 clk after the cs-rise detection cycle.
- Sticky flags clear only on reset.
- Reset asserted mid-frame aborts the frame and clears all state. Once reset releases, a frame already in progress (cs low) is ignored until cs is seen high and then falls again.

Test Plan:
- Single frame: preload recv_msg=0xA5A5_0F0F, then send frame mosi=0x1234_5678 → send_msg=0x1234_5678 with send_val=1; miso bits sampled by the master = 0xA5A5_0F0F; parity=1.
- Empty tx buffer: frame mosi=0xFFFF_FFFF with nothing loaded → miso reads 0x0000_0000; send_msg=0xFFFF_FFFF; parity=0.
- Back-pressure: send_rdy=0, 3 frames 0x1, 0x2, 0x3 → FIFO holds 0x1 and 0x2, overflow=1; after send_rdy=1 the stream delivers 0x1 then 0x2.
- Short frame: cs high after 17 bits → no push, frame_err=1. The next full frame 0xDEAD_BEEF is received correctly.
- Simultaneous push and pop with FIFO full: hold send_rdy=1 while the third frame ends → all three words are delivered in order and overflow stays 0.
- Reset mid-frame: assert reset after 10 bits → all outputs return to reset values; a subsequent frame 0xCAFE_F00D is captured correctly.
